glitch_cfg_ctrl: RTL and testbench

// - Byte-stream command controller that configures the glitch datapath at run time, replacing rebuild-time constants.
// - Parses framed commands from a UART receiver and owns the config registers:

---
 rtl/glitch_cfg_pkg.sv | 59 +++++
 rtl/glitch_cfg_tx.sv | 79 +++++++
 rtl/glitch_cfg_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_glitch_cfg_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_cfg_pkg.sv
// Shared definitions for the glitch configuration controller: opcodes,
// response status codes, FSM state encoding and opcode length helpers.
package glitch_cfg_pkg;

    localparam logic [7:0] OP_WR_FORM  = 8'h01;
    localparam logic [7:0] OP_WR_DELAY = 8'h02;
    localparam logic [7:0] OP_WR_MATCH = 8'h03;
    localparam logic [7:0] OP_WR_CTRL  = 8'h04;
    localparam logic [7:0] OP_RD_FORM  = 8'h81;
    localparam logic [7:0] OP_RD_DELAY = 8'h82;
    localparam logic [7:0] OP_RD_MATCH = 8'h83;
    localparam logic [7:0] OP_RD_CTRL  = 8'h84;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_OP   = 8'h01;
    localparam logic [7:0] ST_BAD_CSUM = 8'h02;
    localparam logic [7:0] ST_TIMEOUT  = 8'h03;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OPCODE,
        S_PAYLOAD,
        S_CHECK,
        S_COMMIT,
        S_RESP_HDR,
        S_RESP_STAT,
        S_RESP_DATA,
        S_RESP_CSUM
    } cfg_state_e;

    function automatic logic op_known(input logic [7:0] op);
        case (op)
            OP_WR_FORM, OP_WR_DELAY, OP_WR_MATCH, OP_WR_CTRL,
            OP_RD_FORM, OP_RD_DELAY, OP_RD_MATCH, OP_RD_CTRL: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // Number of payload bytes that follow the opcode in a command frame.
    function automatic logic [3:0] payload_len(input logic [7:0] op);
        case (op)
            OP_WR_FORM, OP_WR_DELAY: return 4'd8;
            OP_WR_MATCH:             return 4'd4;
            OP_WR_CTRL:              return 4'd1;
            default:                 return 4'd0;
        endcase
    endfunction

    // Number of data bytes returned in the response to a read opcode.
    function automatic logic [3:0] read_len(input logic [7:0] op);
        case (op)
            OP_RD_FORM, OP_RD_DELAY: return 4'd8;
            OP_RD_MATCH:             return 4'd4;
            OP_RD_CTRL:              return 4'd1;
            default:                 return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/glitch_cfg_tx.sv
// Response serializer: emits RESP_BYTE, status, then for reads the data
// bytes little-endian followed by their XOR, over a valid/ready handshake.
module glitch_cfg_tx
    import glitch_cfg_pkg::*;
#(
    parameter logic [7:0] RESP_BYTE = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  status,
    input  logic [63:0] data,
    input  logic [3:0]  length,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        data_last,
    output logic        done
);

    logic        active;
    logic [3:0]  pos;
    logic [7:0]  status_q;
    logic [63:0] data_q;
    logic [3:0]  len_q;
    logic [7:0]  csum;
    logic [2:0]  didx;
    logic        last;
    logic        fire;

    assign tx_valid  = active;
    assign fire      = active & tx_ready;
    assign last      = (len_q == 4'd0) ? (pos == 4'd1) : (pos == len_q + 4'd2);
    assign done      = fire & last;
    assign data_last = active && (len_q != 4'd0) && (pos == len_q + 4'd1);
    assign didx      = 3'(pos - 4'd2);

    always_comb begin
        csum = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < 32'(len_q)) csum = csum ^ data_q[8*i +: 8];
        end
    end

    // Byte selection depends only on registered state, so it holds while stalled.
    always_comb begin
        tx_data = '0;
        if (active) begin
            if (pos == 4'd0)                tx_data = RESP_BYTE;
            else if (pos == 4'd1)           tx_data = status_q;
            else if (pos < len_q + 4'd2)    tx_data = data_q[{didx, 3'b000} +: 8];
            else                            tx_data = csum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            pos      <= '0;
            status_q <= '0;
            data_q   <= '0;
            len_q    <= '0;
        end else if (start && !active) begin
            active   <= 1'b1;
            pos      <= '0;
            status_q <= status;
            data_q   <= data;
            len_q    <= length;
        end else if (fire) begin
            if (last) begin
                active <= 1'b0;
                pos    <= '0;
            end else begin
                pos <= pos + 4'd1;
            end
        end
    end

endmodule

// File: rtl/glitch_cfg_ctrl.sv
// Framed byte-command controller owning the glitch datapath configuration
// registers, with status/readback responses through glitch_cfg_tx.
module glitch_cfg_ctrl
    import glitch_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  RESP_BYTE      = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [63:0] delay_live,
    output logic [63:0] glitch_form,
    output logic [63:0] delay_preload,
    output logic        delay_load,
    output logic [31:0] data_match,
    output logic        glitch_mode,
    output logic        glitch_out_en,
    output logic        busy
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    cfg_state_e    state, state_nx;
    logic [7:0]    status_q, status_nx;
    logic [7:0]    op_q;
    logic [7:0]    csum_q;
    logic [3:0]    idx_q;
    logic [3:0]    len_q;
    logic [63:0]   shadow;
    logic [CW-1:0] tmo_cnt;
    logic          overrun;
    logic          in_frame;
    logic          in_resp;
    logic          timed_out;
    logic          tx_fire;
    logic          tx_done;
    logic          tx_data_last;
    logic [3:0]    resp_len;

    assign in_frame  = state inside {S_OPCODE, S_PAYLOAD, S_CHECK};
    assign in_resp   = state inside {S_RESP_HDR, S_RESP_STAT, S_RESP_DATA, S_RESP_CSUM};
    assign timed_out = in_frame && !rx_valid && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign tx_fire   = tx_valid & tx_ready;
    assign busy      = (state != S_IDLE);
    assign resp_len  = (status_q == ST_OK) ? read_len(op_q) : 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            status_q <= ST_OK;
        end else begin
            state    <= state_nx;
            status_q <= status_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        status_nx = status_q;
        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_nx = S_OPCODE;
            end
            S_OPCODE: begin
                if (rx_valid) begin
                    if (!op_known(rx_data)) begin
                        state_nx  = S_RESP_HDR;
                        status_nx = ST_BAD_OP;
                    end else if (payload_len(rx_data) != 4'd0) begin
                        state_nx = S_PAYLOAD;
                    end else begin
                        state_nx = S_CHECK;
                    end
                end else if (timed_out) begin
                    state_nx  = S_RESP_HDR;
                    status_nx = ST_TIMEOUT;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    if (idx_q == len_q - 4'd1) state_nx = S_CHECK;
                end else if (timed_out) begin
                    state_nx  = S_RESP_HDR;
                    status_nx = ST_TIMEOUT;
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_nx = S_COMMIT;
                    end else begin
                        state_nx  = S_RESP_HDR;
                        status_nx = ST_BAD_CSUM;
                    end
                end else if (timed_out) begin
                    state_nx  = S_RESP_HDR;
                    status_nx = ST_TIMEOUT;
                end
            end
            S_COMMIT: begin
                state_nx  = S_RESP_HDR;
                status_nx = ST_OK;
            end
            S_RESP_HDR: begin
                if (tx_fire) state_nx = S_RESP_STAT;
            end
            S_RESP_STAT: begin
                if (tx_fire) state_nx = tx_done ? S_IDLE : S_RESP_DATA;
            end
            S_RESP_DATA: begin
                if (tx_fire && tx_data_last) state_nx = S_RESP_CSUM;
            end
            S_RESP_CSUM: begin
                if (tx_done) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= '0;
            csum_q        <= '0;
            idx_q         <= '0;
            len_q         <= '0;
            shadow        <= '0;
            tmo_cnt       <= '0;
            overrun       <= 1'b0;
            glitch_form   <= '0;
            delay_preload <= '0;
            delay_load    <= 1'b0;
            data_match    <= '0;
            glitch_mode   <= 1'b0;
            glitch_out_en <= 1'b0;
        end else begin
            delay_load <= 1'b0;

            if (in_frame && !rx_valid) tmo_cnt <= tmo_cnt + CW'(1);
            else                       tmo_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        shadow <= '0;
                        csum_q <= '0;
                        idx_q  <= '0;
                    end
                end
                S_OPCODE: begin
                    if (rx_valid) begin
                        op_q   <= rx_data;
                        csum_q <= rx_data;
                        len_q  <= payload_len(rx_data);
                    end
                end
                S_PAYLOAD: begin
                    if (rx_valid) begin
                        shadow[{idx_q[2:0], 3'b000} +: 8] <= rx_data;
                        csum_q <= csum_q ^ rx_data;
                        idx_q  <= idx_q + 4'd1;
                    end
                end
                // delay_load is registered so it coincides with the new preload value.
                S_COMMIT: begin
                    case (op_q)
                        OP_WR_FORM:  glitch_form <= shadow;
                        OP_WR_DELAY: begin
                            delay_preload <= shadow;
                            delay_load    <= 1'b1;
                        end
                        OP_WR_MATCH: data_match <= shadow[31:0];
                        OP_WR_CTRL: begin
                            glitch_mode   <= shadow[0];
                            glitch_out_en <= shadow[1];
                        end
                        OP_RD_FORM:  shadow <= glitch_form;
                        OP_RD_DELAY: shadow <= delay_live;
                        OP_RD_MATCH: shadow <= {32'h0, data_match};
                        OP_RD_CTRL:  shadow <= {61'h0, overrun, glitch_out_en, glitch_mode};
                        default: ;
                    endcase
                end
                default: ;
            endcase

            if (in_resp && rx_valid)
                overrun <= 1'b1;
            else if (state == S_RESP_CSUM && tx_done && op_q == OP_RD_CTRL && status_q == ST_OK)
                overrun <= 1'b0;
        end
    end

    glitch_cfg_tx #(
        .RESP_BYTE(RESP_BYTE)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (state == S_RESP_HDR),
        .status   (status_q),
        .data     (shadow),
        .length   (resp_len),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .data_last(tx_data_last),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_glitch_cfg_ctrl.sv
// Randomized self-checking bench for glitch_cfg_ctrl against a frame-level
// reference model of the command set.
`timescale 1ns/1ps
module tb_glitch_cfg_ctrl;

    localparam int unsigned TMO = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [63:0] delay_live = '0;
    logic [63:0] glitch_form;
    logic [63:0] delay_preload;
    logic        delay_load;
    logic [31:0] data_match;
    logic        glitch_mode;
    logic        glitch_out_en;
    logic        busy;

    always #5 clk = ~clk;

    glitch_cfg_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .SYNC_BYTE     (8'hA5),
        .RESP_BYTE     (8'h5A)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .delay_live   (delay_live),
        .glitch_form  (glitch_form),
        .delay_preload(delay_preload),
        .delay_load   (delay_load),
        .data_match   (data_match),
        .glitch_mode  (glitch_mode),
        .glitch_out_en(glitch_out_en),
        .busy         (busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [63:0] m_form  = '0;
    logic [63:0] m_delay = '0;
    logic [31:0] m_match = '0;
    logic        m_mode  = 1'b0;
    logic        m_en    = 1'b0;
    logic        m_ovr   = 1'b0;
    int unsigned exp_dl  = 0;
    logic [7:0]  exp_q[$];

    // Response capture; ready_mode: 0 random, 1 always ready, 2 stalled
    logic [7:0]  got_q[$];
    int unsigned ready_mode = 1;
    int unsigned dl_pulses  = 0;
    bit          stalled    = 1'b0;
    logic [7:0]  stall_data = '0;

    always @(negedge clk) begin
        case (ready_mode)
            0:       tx_ready = ($urandom_range(0, 3) != 0);
            1:       tx_ready = 1'b1;
            default: tx_ready = 1'b0;
        endcase
        #1;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check_val("tx_hold_valid", 64'(tx_valid), 64'd1);
                check_val("tx_hold_data", 64'(tx_data), 64'(stall_data));
            end
            stalled    = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (delay_load) dl_pulses++;
        end
    end

    function automatic int unsigned plen(input logic [7:0] op);
        case (op)
            8'h01, 8'h02: return 8;
            8'h03:        return 4;
            8'h04:        return 1;
            default:      return 0;
        endcase
    endfunction

    function automatic bit known(input logic [7:0] op);
        return op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h81, 8'h82, 8'h83, 8'h84};
    endfunction

    // Apply one command to the model and build the expected response bytes.
    task automatic model_cmd(input logic [7:0] op, input logic [63:0] pl, input bit good);
        logic [63:0] v;
        logic [7:0]  cs;
        int unsigned n;
        v = '0; n = 0; cs = '0;
        exp_dl = 0;
        exp_q.delete();
        exp_q.push_back(8'h5A);
        if (!known(op))     begin exp_q.push_back(8'h01); return; end
        if (!good)          begin exp_q.push_back(8'h02); return; end
        exp_q.push_back(8'h00);
        case (op)
            8'h01: m_form = pl;
            8'h02: begin m_delay = pl; exp_dl = 1; end
            8'h03: m_match = pl[31:0];
            8'h04: begin m_mode = pl[0]; m_en = pl[1]; end
            8'h81: begin v = m_form;             n = 8; end
            8'h82: begin v = delay_live;         n = 8; end
            8'h83: begin v = {32'h0, m_match};   n = 4; end
            default: begin v = {61'h0, m_ovr, m_en, m_mode}; n = 1; m_ovr = 1'b0; end
        endcase
        if (n != 0) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back(v[8*i +: 8]);
                cs = cs ^ v[8*i +: 8];
            end
            exp_q.push_back(cs);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [63:0] pl, input bit good);
        logic [7:0] cs;
        cs = op;
        send_byte(8'hA5);
        gap();
        send_byte(op);
        if (!known(op)) return;
        for (int i = 0; i < int'(plen(op)); i++) begin
            gap();
            send_byte(pl[8*i +: 8]);
            cs = cs ^ pl[8*i +: 8];
        end
        gap();
        send_byte(good ? cs : cs ^ 8'(1 << $urandom_range(0, 7)));
    endtask

    task automatic collect_resp(input string tag);
        int unsigned budget;
        budget = 0;
        while (got_q.size() < exp_q.size() && budget < 400) begin
            @(negedge clk); #2;
            budget++;
        end
        repeat (2) @(negedge clk);
        #2;
        check_val({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check_val($sformatf("%s_b%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        check_val({tag, "_idle"}, 64'(busy), 64'd0);
        got_q.delete();
    endtask

    task automatic check_cfg(input string tag);
        check_val({tag, "_form"},  glitch_form, m_form);
        check_val({tag, "_delay"}, delay_preload, m_delay);
        check_val({tag, "_match"}, 64'(data_match), 64'(m_match));
        check_val({tag, "_ctrl"},  64'({glitch_out_en, glitch_mode}), 64'({m_en, m_mode}));
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] op, input logic [63:0] pl, input bit good);
        int unsigned dl0;
        dl0 = dl_pulses;
        model_cmd(op, pl, good);
        send_frame(op, pl, good);
        collect_resp(tag);
        check_val({tag, "_dload"}, 64'(dl_pulses - dl0), 64'(exp_dl));
        check_cfg(tag);
    endtask

    task automatic wait_txv(input string tag);
        int unsigned cyc;
        cyc = 0;
        while (!tx_valid && cyc < 200) begin @(negedge clk); #2; cyc++; end
        check_val({tag, "_txv"}, 64'(tx_valid), 64'd1);
    endtask

    initial begin
        int unsigned cyc;
        logic [7:0]  op;
        logic [7:0]  g;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check_val("rst_ctrl", 64'({glitch_out_en, glitch_mode, delay_load, busy, tx_valid}), 64'd0);
        check_val("rst_cfg", glitch_form | delay_preload | 64'(data_match) | 64'(tx_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // WR_CTRL with exact latency checks
        ready_mode = 1;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h03); send_byte(8'h07);
        check_val("ctrl_lat1", 64'({glitch_out_en, glitch_mode}), 64'd0);
        @(negedge clk); #2;
        check_val("ctrl_lat2", 64'({glitch_out_en, glitch_mode}), 64'd3);
        check_val("ctrl_txv2", 64'(tx_valid), 64'd0);
        @(negedge clk); #2;
        check_val("ctrl_txv3", 64'(tx_valid), 64'd1);
        model_cmd(8'h04, 64'h3, 1'b1);
        collect_resp("ctrl");
        check_cfg("ctrl");

        run_cmd("wrdly", 8'h02, 64'h0123456789ABCDEF, 1'b1);
        run_cmd("badcs", 8'h03, 64'hDEADBEEF, 1'b0);
        run_cmd("badop", 8'h7E, 64'h0, 1'b1);

        // Timeout mid-payload
        send_byte(8'hA5); send_byte(8'h01);
        repeat (3) send_byte(8'($urandom));
        cyc = 0;
        while (!tx_valid && cyc < TMO + 20) begin @(negedge clk); #2; cyc++; end
        check_val("tmo_latency", 64'(cyc), 64'(TMO + 1));
        exp_q.delete(); exp_q.push_back(8'h5A); exp_q.push_back(8'h03);
        collect_resp("tmo");
        check_cfg("tmo");

        // RD_DELAY under backpressure
        ready_mode = 2;
        delay_live = 64'h10;
        model_cmd(8'h82, 64'h0, 1'b1);
        send_frame(8'h82, 64'h0, 1'b1);
        wait_txv("rdly");
        repeat (20) @(negedge clk);
        #2;
        check_val("rdly_hold", 64'({tx_valid, tx_data}), 64'h15A);
        ready_mode = 1;
        collect_resp("rdly");

        // Overrun flag set by a byte during a response, cleared by RD_CTRL
        ready_mode = 2;
        model_cmd(8'h81, 64'h0, 1'b1);
        send_frame(8'h81, 64'h0, 1'b1);
        wait_txv("ovr");
        send_byte(8'h33);
        m_ovr = 1'b1;
        ready_mode = 1;
        collect_resp("ovr_rd");
        run_cmd("ovr_ctrl1", 8'h84, 64'h0, 1'b1);
        run_cmd("ovr_ctrl2", 8'h84, 64'h0, 1'b1);

        // Randomized command mix
        ready_mode = 0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g);
            end
            case ($urandom_range(0, 8))
                0: op = 8'h01;  1: op = 8'h02;  2: op = 8'h03;  3: op = 8'h04;
                4: op = 8'h81;  5: op = 8'h82;  6: op = 8'h83;  7: op = 8'h84;
                default: begin
                    op = 8'h7F;
                    for (int k = 0; k < 8; k++) begin
                        g = 8'($urandom);
                        if (!known(g)) op = g;
                    end
                end
            endcase
            delay_live = {32'($urandom), 32'($urandom)};
            run_cmd($sformatf("rnd%0d", it), op, {32'($urandom), 32'($urandom)},
                    ($urandom_range(0, 7) != 0));
        end

        // Async reset in the middle of a response
        ready_mode = 2;
        model_cmd(8'h81, 64'h0, 1'b1);
        send_frame(8'h81, 64'h0, 1'b1);
        wait_txv("arst");
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_val("arst_out", 64'({tx_valid, busy, glitch_out_en, glitch_mode}), 64'd0);
        check_val("arst_cfg", glitch_form | delay_preload | 64'(data_match), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        m_form = '0; m_delay = '0; m_match = '0; m_mode = 1'b0; m_en = 1'b0; m_ovr = 1'b0;
        ready_mode = 1;
        run_cmd("post_rst", 8'h84, 64'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
